arp_cache_table: RTL

- Responder for the IP transmit path's seek-IP/seek-MAC interface. Resolves a next-hop IPv4 address to a MAC address from a small fully-associative cache.
- On a miss it triggers an ARP request, waits for the ARP receive path to learn the entry, and retries with a timeout.
- Sits between the IP layer and the ARP TX/RX blocks inside the Ethernet stack.

---
 rtl/arp_cache_table.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/arp_cache_table.sv
`default_nettype none
// ============================================================================
// Module   : arp_cache_table
// Purpose  : Resolves a next-hop IPv4 address to a MAC address using a small
//            fully-associative cache. On a miss it requests an ARP lookup,
//            waits for the receive path to learn the entry and retries with
//            a timeout before reporting failure.
// Options  : define ARP_CACHE_AGING_EN to age out entries that are not
//            refreshed (tick counter plus an 8-bit age per entry).
// Revision : 1.0 - initial release
// ============================================================================
module arp_cache_table #(
  parameter int          P_DEPTH         = 8,
  parameter logic [31:0] P_REPLY_TIMEOUT = 32'd156250,
  parameter int          P_MAX_RETRY     = 2,
  parameter logic [31:0] P_AGE_TICK      = 32'd156250000,
  parameter logic [7:0]  P_AGE_MAX       = 8'd60
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_seek_ip,
  input  logic        i_seek_ip_valid,
  output logic [47:0] o_seek_mac,
  output logic        o_seek_mac_valid,
  output logic        o_seek_fail,
  output logic        o_busy,
  input  logic [31:0] i_update_ip,
  input  logic [47:0] i_update_mac,
  input  logic        i_update_valid,
  input  logic        i_flush,
  output logic        o_arp_req,
  output logic [31:0] o_arp_req_ip
);

  localparam int C_IDX_W = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOOKUP     = 3'd1,
    RESPOND    = 3'd2,
    ARP_REQ    = 3'd3,
    WAIT_REPLY = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [31:0]          r_seek_ip;
  logic [47:0]          r_result_mac;
  logic                 r_result_fail;
  logic [31:0]          r_timer;
  logic [7:0]           r_retry;
  logic [31:0]          r_arp_req_ip;

  logic [P_DEPTH-1:0]   r_valid;
  logic [31:0]          r_ip  [P_DEPTH];
  logic [47:0]          r_mac [P_DEPTH];
  logic [C_IDX_W-1:0]   r_repl_ptr;

  logic                 w_upd_ok;
  logic                 w_reply;
  logic [P_DEPTH-1:0]   w_hit_vec;
  logic [47:0]          w_table_mac;
  logic                 w_lookup_hit;
  logic [47:0]          w_lookup_mac;
  logic                 w_upd_match;
  logic [C_IDX_W-1:0]   w_match_idx;
  logic                 w_has_free;
  logic [C_IDX_W-1:0]   w_free_idx;
  logic [C_IDX_W-1:0]   w_wr_idx;
  logic                 w_wr_en;
  logic                 w_wr_replace;
  logic                 w_timeout;
  logic                 w_retry_left;

  // An IP of zero is never a real neighbour, so such updates are ignored.
  assign w_upd_ok     = i_update_valid && (i_update_ip != 32'd0);
  assign w_reply      = w_upd_ok && (i_update_ip == r_seek_ip);
  assign w_timeout    = (r_timer == (P_REPLY_TIMEOUT - 32'd1));
  assign w_retry_left = (r_retry < 8'(P_MAX_RETRY));

  // Parallel compare of the latched seek IP against every valid entry.
  always_comb begin
    w_hit_vec   = '0;
    w_table_mac = '0;
    for (int i = 0; i < P_DEPTH; i++) begin
      if (r_valid[i] && (r_ip[i] == r_seek_ip)) begin
        w_hit_vec[i] = 1'b1;
        w_table_mac  = w_table_mac | r_mac[i];
      end
    end
  end

  // A same-cycle update for the sought IP wins; a flush forces a miss so a
  // flushed lookup can only complete through the ARP path.
  assign w_lookup_hit = !i_flush && (w_reply || (|w_hit_vec));
  assign w_lookup_mac = w_reply ? i_update_mac : w_table_mac;

  // Find the slot an update should land in: existing IP, else lowest free.
  always_comb begin
    w_upd_match = 1'b0;
    w_match_idx = '0;
    w_has_free  = 1'b0;
    w_free_idx  = '0;
    for (int i = P_DEPTH - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_ip[i] == i_update_ip)) begin
        w_upd_match = 1'b1;
        w_match_idx = C_IDX_W'(i);
      end
      if (!r_valid[i]) begin
        w_has_free = 1'b1;
        w_free_idx = C_IDX_W'(i);
      end
    end
  end

  assign w_wr_en      = w_upd_ok && !i_flush;
  assign w_wr_replace = w_wr_en && !w_upd_match && !w_has_free;
  assign w_wr_idx     = w_upd_match ? w_match_idx :
                        (w_has_free ? w_free_idx : r_repl_ptr);

`ifdef ARP_CACHE_AGING_EN
  logic [31:0] r_age_cnt;
  logic [7:0]  r_age [P_DEPTH];
  logic        w_age_tick;

  assign w_age_tick = (r_age_cnt == (P_AGE_TICK - 32'd1));

  // Free-running tick prescaler for entry aging.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_age_cnt <= '0;
    end else if (w_age_tick) begin
      r_age_cnt <= '0;
    end else begin
      r_age_cnt <= r_age_cnt + 32'd1;
    end
  end
`else
  // Aging parameters have no effect in this build.
  if ((P_AGE_TICK == 32'd0) || (P_AGE_MAX == 8'd0)) begin : g_age_disabled
  end
`endif

  // Entry valid bits, replacement pointer and (optionally) entry ages.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_valid    <= '0;
      r_repl_ptr <= '0;
`ifdef ARP_CACHE_AGING_EN
      for (int i = 0; i < P_DEPTH; i++) r_age[i] <= '0;
`endif
    end else begin
`ifdef ARP_CACHE_AGING_EN
      for (int i = 0; i < P_DEPTH; i++) begin
        if (w_age_tick && r_valid[i]) begin
          if (r_age[i] != 8'hFF) r_age[i] <= r_age[i] + 8'd1;
          if (({1'b0, r_age[i]} + 9'd1) >= {1'b0, P_AGE_MAX}) r_valid[i] <= 1'b0;
        end
        if ((r_state == LOOKUP) && w_hit_vec[i]) r_age[i] <= '0;
      end
`endif
      if (i_flush) begin
        r_valid <= '0;
      end else if (w_wr_en) begin
        r_valid[w_wr_idx] <= 1'b1;
`ifdef ARP_CACHE_AGING_EN
        r_age[w_wr_idx] <= '0;
`endif
        if (w_wr_replace) begin
          r_repl_ptr <= (r_repl_ptr == C_IDX_W'(P_DEPTH - 1)) ? '0 : r_repl_ptr + 1'b1;
        end
      end
    end
  end

  // Entry payload storage; validity is tracked separately so no reset needed.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_ip[w_wr_idx]  <= i_update_ip;
      r_mac[w_wr_idx] <= i_update_mac;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic and state-decoded output strobes.
  always_comb begin
    w_state_next     = r_state;
    o_busy           = (r_state != IDLE);
    o_seek_mac_valid = 1'b0;
    o_seek_fail      = 1'b0;
    o_seek_mac       = '0;
    o_arp_req        = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_seek_ip_valid) w_state_next = LOOKUP;
      end
      LOOKUP: begin
        w_state_next = w_lookup_hit ? RESPOND : ARP_REQ;
      end
      RESPOND: begin
        o_seek_mac_valid = 1'b1;
        o_seek_fail      = r_result_fail;
        o_seek_mac       = r_result_mac;
        w_state_next     = IDLE;
      end
      ARP_REQ: begin
        o_arp_req    = 1'b1;
        w_state_next = WAIT_REPLY;
      end
      WAIT_REPLY: begin
        if (w_reply)        w_state_next = RESPOND;
        else if (w_timeout) w_state_next = w_retry_left ? ARP_REQ : RESPOND;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Lookup context: seek IP, result, reply timer and retry count.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_seek_ip     <= '0;
      r_result_mac  <= '0;
      r_result_fail <= 1'b0;
      r_timer       <= '0;
      r_retry       <= '0;
      r_arp_req_ip  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_seek_ip_valid) begin
            r_seek_ip <= i_seek_ip;
            r_retry   <= '0;
          end
        end
        LOOKUP: begin
          r_result_mac  <= w_lookup_mac;
          r_result_fail <= 1'b0;
        end
        ARP_REQ: begin
          r_timer <= '0;
        end
        WAIT_REPLY: begin
          r_timer <= r_timer + 32'd1;
          if (w_reply) begin
            r_result_mac  <= i_update_mac;
            r_result_fail <= 1'b0;
          end else if (w_timeout) begin
            if (w_retry_left) begin
              r_retry <= r_retry + 8'd1;
            end else begin
              r_result_mac  <= 48'hFFFF_FFFF_FFFF;
              r_result_fail <= 1'b1;
            end
          end
        end
        default: ;
      endcase
      // Target IP is loaded as the request strobe starts and held afterwards.
      if ((w_state_next == ARP_REQ) && (r_state != ARP_REQ)) r_arp_req_ip <= r_seek_ip;
    end
  end

  assign o_arp_req_ip = r_arp_req_ip;

endmodule
`default_nettype wire
